// File: rtl/mem_arbiter_pkg.sv
// Shared types for the IFU/LSU memory arbiter: FSM states, owner encoding
// and the latched request bundle.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StReq  = 2'd1,
      StWait = 2'd2
   } state_e;

   typedef enum logic {
      OwnerIfu = 1'b0,
      OwnerLsu = 1'b1
   } owner_e;

   typedef struct packed {
      logic [31:0] addr;
      logic        wen;
      logic [31:0] wdata;
      logic [3:0]  wmask;
   } mem_req_t;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin arbiter: req[0]=IFU, req[1]=LSU; last_grant holds the
// owner of the most recent update (resets to IFU, so LSU wins the first tie).
module rr_arb2
   import mem_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] req,
   input  logic       update,
   output logic [1:0] grant,
   output logic       last_grant
);

   always_comb begin
      grant = 2'b00;
      case (req)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = (last_grant == OwnerLsu) ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= OwnerIfu;
      end else if (update) begin
         last_grant <= grant[1];
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates IFU and LSU onto one memory port, one outstanding transaction,
// with a WAIT-cycle timeout that returns an error response to the owner.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ifu_req_valid,
   output logic        ifu_req_ready,
   input  logic [31:0] ifu_addr,
   output logic        ifu_resp_valid,
   output logic [31:0] ifu_rdata,
   output logic        ifu_resp_err,
   input  logic        lsu_req_valid,
   output logic        lsu_req_ready,
   input  logic [31:0] lsu_addr,
   input  logic        lsu_wen,
   input  logic [31:0] lsu_wdata,
   input  logic [3:0]  lsu_wmask,
   output logic        lsu_resp_valid,
   output logic [31:0] lsu_rdata,
   output logic        lsu_resp_err,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic [31:0] mem_addr,
   output logic        mem_wen,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wmask,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_rdata
);

   localparam logic [15:0] TimeoutLast = 16'(TIMEOUT - 1);

   state_e      state_q, state_d;
   logic [15:0] cnt_q, cnt_d;
   mem_req_t    req_q, req_d;

   logic [1:0]  arb_req, grant;
   logic        last_grant;
   logic        resp_valid, resp_err;
   logic [31:0] resp_rdata;

   assign arb_req = (state_q == StIdle) ? {lsu_req_valid, ifu_req_valid} : 2'b00;

   // last_grant only moves on acceptance, so it doubles as the in-flight owner.
   rr_arb2 u_rr_arb2 (
      .clk        (clk),
      .rst        (rst),
      .req        (arb_req),
      .update     (|grant),
      .grant      (grant),
      .last_grant (last_grant)
   );

   always_comb begin
      state_d        = state_q;
      cnt_d          = cnt_q;
      req_d          = req_q;
      ifu_req_ready  = 1'b0;
      lsu_req_ready  = 1'b0;
      mem_req_valid  = 1'b0;
      mem_addr       = '0;
      mem_wen        = 1'b0;
      mem_wdata      = '0;
      mem_wmask      = '0;
      resp_valid     = 1'b0;
      resp_err       = 1'b0;
      resp_rdata     = '0;
      if (!rst) begin
         unique case (state_q)
            StIdle: begin
               ifu_req_ready = grant[0];
               lsu_req_ready = grant[1];
               if (grant[1]) begin
                  req_d   = '{addr: lsu_addr, wen: lsu_wen, wdata: lsu_wdata, wmask: lsu_wmask};
                  state_d = StReq;
               end else if (grant[0]) begin
                  req_d   = '{addr: ifu_addr, wen: 1'b0, wdata: '0, wmask: '0};
                  state_d = StReq;
               end
            end
            StReq: begin
               mem_req_valid = 1'b1;
               mem_addr      = req_q.addr;
               mem_wen       = req_q.wen;
               mem_wdata     = req_q.wdata;
               mem_wmask     = req_q.wmask;
               if (mem_req_ready) begin
                  cnt_d   = '0;
                  state_d = StWait;
               end
            end
            StWait: begin
               cnt_d = cnt_q + 16'd1;
               // A real response takes priority over a coincident timeout.
               if (mem_resp_valid || (cnt_q == TimeoutLast)) begin
                  resp_valid = 1'b1;
                  resp_err   = ~mem_resp_valid;
                  resp_rdata = mem_resp_valid ? mem_rdata : '0;
                  state_d    = StIdle;
               end
            end
            default: state_d = StIdle;
         endcase
      end
   end

   assign ifu_resp_valid = resp_valid & (last_grant == OwnerIfu);
   assign ifu_resp_err   = resp_err & (last_grant == OwnerIfu);
   assign ifu_rdata      = (last_grant == OwnerIfu) ? resp_rdata : '0;
   assign lsu_resp_valid = resp_valid & (last_grant == OwnerLsu);
   assign lsu_resp_err   = resp_err & (last_grant == OwnerLsu);
   assign lsu_rdata      = (last_grant == OwnerLsu) ? resp_rdata : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         req_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
      end
   end

endmodule
